// File: rtl/mag_sq_framer.sv
// Squares complex FFT bins (re^2+im^2), shifts and saturates them, collects whole
// frames in a ping-pong buffer and re-emits each frame contiguously with an idle gap.
module mag_sq_framer #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int IN_W  = 16,
    parameter int SHIFT = 0,
    parameter int GAP   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bin_valid,
    output logic                   bin_ready,
    input  logic signed [IN_W-1:0] bin_re,
    input  logic signed [IN_W-1:0] bin_im,
    input  logic                   bin_last,
    output logic                   mag_valid,
    output logic [W-1:0]           mag_sq,
    output logic                   frame_start,
    output logic                   frame_err,
    output logic [15:0]            sat_count,
    output logic [15:0]            frame_count
);
    localparam int PROD_W = 2 * IN_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int IDX_W  = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [SUM_W-1:0] MAX_MAG  = SUM_W'({W{1'b1}});
    localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

    logic signed [PROD_W-1:0] re_ext, im_ext;
    logic                     accept;
    logic                     s1_valid, s1_last;
    logic [PROD_W-1:0]        s1_re2, s1_im2;
    logic [SUM_W-1:0]         sum, shifted;
    logic                     s2_valid, s2_last, s2_sat;
    logic [W-1:0]             s2_mag;
    logic [IDX_W-1:0]         wr_idx, rd_idx, s1_idx;
    logic                     fill_bank, emit_bank;
    logic [1:0]               full;
    logic                     s2_at_end, frame_done, frame_bad, final_pending;
    logic [W-1:0]             bank [2][N];
    state_t                   state, next_state;
    logic                     emit_done;
    logic [3:0]               gap_cnt;

    assign re_ext = PROD_W'(bin_re);
    assign im_ext = PROD_W'(bin_im);
    assign accept = bin_valid && bin_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_re2   <= '0;
            s1_im2   <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= bin_last;
            s1_re2   <= $unsigned(re_ext * re_ext);
            s1_im2   <= $unsigned(im_ext * im_ext);
        end
    end

    assign sum     = {1'b0, s1_re2} + {1'b0, s1_im2};
    assign shifted = sum >> SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_mag   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_sat   <= (shifted > MAX_MAG);
            s2_mag   <= (shifted > MAX_MAG) ? '1 : shifted[W-1:0];
        end
    end

    // Any write at index N-1, or any write flagged last, ends the current fill attempt.
    assign s2_at_end  = (wr_idx == LAST_IDX);
    assign frame_done = s2_valid && s2_last && s2_at_end;
    assign frame_bad  = s2_valid && (s2_last != s2_at_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx    <= '0;
            fill_bank <= 1'b0;
            frame_err <= 1'b0;
            sat_count <= '0;
        end else begin
            frame_err <= frame_bad;
            if (s2_valid) begin
                sat_count <= sat_count + 16'(s2_sat);
                wr_idx    <= (s2_last || s2_at_end) ? '0 : wr_idx + IDX_W'(1);
            end
            if (frame_done)
                fill_bank <= ~fill_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (s2_valid)
            bank[fill_bank][wr_idx] <= s2_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (emit_done)
                full[emit_bank] <= 1'b0;
            if (frame_done)
                full[fill_bank] <= 1'b1;
        end
    end

    // A completing bin still in the pipe will flip the fill side onto the other bank,
    // so stop accepting while that bank is still occupied.
    assign s1_idx        = !s2_valid ? wr_idx :
                           (s2_last || s2_at_end) ? '0 : wr_idx + IDX_W'(1);
    assign final_pending = frame_done || (s1_valid && s1_last && (s1_idx == LAST_IDX));
    assign bin_ready     = !reset && !full[fill_bank] && !(final_pending && full[~fill_bank]);

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        mag_valid   = 1'b0;
        mag_sq      = '0;
        frame_start = 1'b0;
        emit_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (full[emit_bank])
                    next_state = S_EMIT;
            end
            S_EMIT: begin
                mag_valid   = 1'b1;
                mag_sq      = bank[emit_bank][rd_idx];
                frame_start = (rd_idx == '0);
                if (rd_idx == LAST_IDX) begin
                    emit_done  = 1'b1;
                    next_state = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx      <= '0;
            gap_cnt     <= '0;
            emit_bank   <= 1'b0;
            frame_count <= '0;
        end else begin
            if (state == S_EMIT && !emit_done)
                rd_idx <= rd_idx + IDX_W'(1);
            else
                rd_idx <= '0;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (emit_done) begin
                emit_bank   <= ~emit_bank;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mag_sq_framer.sv
// Bench for mag_sq_framer: directed vector tables, multi-cycle corner sequences and
// randomized frames checked against a frame-level model of the accepted bin stream.
module tb_mag_sq_framer;
    localparam int N   = 8;
    localparam int GAP = 2;

    typedef struct {
        int re;
        int im;
        bit last;
        int exp_mag;
        int exp_mag16;
    } vec_t;

    logic               clk       = 1'b0;
    logic               reset     = 1'b1;
    logic               bin_valid = 1'b0;
    logic signed [15:0] bin_re    = '0;
    logic signed [15:0] bin_im    = '0;
    logic               bin_last  = 1'b0;
    logic               bin_ready, mag_valid, frame_start, frame_err;
    logic [15:0]        mag_sq, sat_count, frame_count;
    logic               bin_ready16, mag_valid16, frame_start16, frame_err16;
    logic [15:0]        mag_sq16, sat_count16, frame_count16;

    mag_sq_framer #(.N(N), .W(16), .IN_W(16), .SHIFT(0), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .bin_re(bin_re), .bin_im(bin_im), .bin_last(bin_last),
        .mag_valid(mag_valid), .mag_sq(mag_sq), .frame_start(frame_start),
        .frame_err(frame_err), .sat_count(sat_count), .frame_count(frame_count)
    );

    mag_sq_framer #(.N(N), .W(16), .IN_W(16), .SHIFT(16), .GAP(GAP)) dut16 (
        .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_ready(bin_ready16),
        .bin_re(bin_re), .bin_im(bin_im), .bin_last(bin_last),
        .mag_valid(mag_valid16), .mag_sq(mag_sq16), .frame_start(frame_start16),
        .frame_err(frame_err16), .sat_count(sat_count16), .frame_count(frame_count16)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int cur_re[$], cur_im[$];
    int exp_q[$], exp_q16[$];
    int exp_err, exp_sat, exp_sat16, exp_frames, last_accept_cyc;
    int got[$], got16[$], valid_cyc[$], start_cyc[$];
    int err_pulses, bad_idle;
    bit ready_at [int];

    vec_t basic_vec [N];
    vec_t sat_vec [N];

    function automatic longint raw_mag(int re, int im, int sh);
        return (longint'(re) * re + longint'(im) * im) >>> sh;
    endfunction

    function automatic int mag_of(int re, int im, int sh);
        longint m;
        m = raw_mag(re, im, sh);
        return (m > 65535) ? 65535 : int'(m);
    endfunction

    // A frame is emitted only when its N-th accepted bin is the one flagged last.
    function automatic void model_accept(int re, int im, bit last);
        int idx;
        idx = cur_re.size();
        cur_re.push_back(re);
        cur_im.push_back(im);
        if (raw_mag(re, im, 0) > 65535) exp_sat++;
        if (raw_mag(re, im, 16) > 65535) exp_sat16++;
        if (last && idx == N - 1) begin
            foreach (cur_re[i]) begin
                exp_q.push_back(mag_of(cur_re[i], cur_im[i], 0));
                exp_q16.push_back(mag_of(cur_re[i], cur_im[i], 16));
            end
            exp_frames++;
            last_accept_cyc = cyc;
            cur_re.delete();
            cur_im.delete();
        end else if (last || idx == N - 1) begin
            exp_err++;
            cur_re.delete();
            cur_im.delete();
        end
    endfunction

    function automatic void clear_model();
        cur_re.delete(); cur_im.delete();
        exp_q.delete(); exp_q16.delete();
        got.delete(); got16.delete(); valid_cyc.delete(); start_cyc.delete();
        ready_at.delete();
        exp_err = 0; exp_sat = 0; exp_sat16 = 0; exp_frames = 0; last_accept_cyc = 0;
        err_pulses = 0; bad_idle = 0;
    endfunction

    function automatic void checkEq(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 65535)) - 32768;
            1:       return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            default: return int'($urandom_range(0, 600)) - 300;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            cur_re.delete();
            cur_im.delete();
        end else begin
            ready_at[cyc] = bin_ready;
            if (mag_valid) begin
                got.push_back(int'(mag_sq));
                got16.push_back(int'(mag_sq16));
                valid_cyc.push_back(cyc);
            end else if (mag_sq != 0 || mag_sq16 != 0 || frame_start) begin
                bad_idle++;
            end
            if (frame_start) start_cyc.push_back(cyc);
            if (frame_err) err_pulses++;
            if (bin_valid && bin_ready) model_accept(int'(bin_re), int'(bin_im), bin_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int re, input int im, input bit last);
        int waited;
        waited = 0;
        bin_valid = 1'b1;
        bin_re    = 16'(re);
        bin_im    = 16'(im);
        bin_last  = last;
        while (1) begin
            @(negedge clk);
            if (bin_ready) break;
            waited++;
            if (waited > 500) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept timeout: bin_ready stayed %0d, expected 1", bin_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic start_phase();
        bin_valid = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        clear_model();
        reset = 1'b0;
    endtask

    task automatic drain(string name);
        int waited;
        waited = 0;
        while (got.size() < exp_q.size() && waited < 400) begin
            tick();
            waited++;
        end
        if (got.size() < exp_q.size()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s drain timeout: got %0d outputs, expected %0d",
                     name, got.size(), exp_q.size());
        end
        repeat (15) tick();
    endtask

    task automatic checkOutput(string name);
        int n, bad;
        checkEq({name, " output count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkEq($sformatf("%s mag[%0d]", name, i), got[i], exp_q[i]);
            checkEq($sformatf("%s mag16[%0d]", name, i), got16[i], exp_q16[i]);
        end
        checkEq({name, " frame_count"}, frame_count, exp_frames);
        checkEq({name, " frame_count16"}, frame_count16, exp_frames);
        checkEq({name, " sat_count"}, sat_count, exp_sat);
        checkEq({name, " sat_count16"}, sat_count16, exp_sat16);
        checkEq({name, " frame_err pulses"}, err_pulses, exp_err);
        checkEq({name, " nonzero idle outputs"}, bad_idle, 0);
        checkEq({name, " frame_start count"}, start_cyc.size(), exp_frames);
        bad = 0;
        for (int f = 0; f < exp_frames; f++) begin
            if ((f + 1) * N <= valid_cyc.size()) begin
                for (int k = 0; k < N; k++)
                    if (valid_cyc[f*N + k] != valid_cyc[f*N] + k) bad++;
                if (f >= start_cyc.size() || start_cyc[f] != valid_cyc[f*N]) bad++;
            end else begin
                bad++;
            end
        end
        checkEq({name, " contiguity/frame_start errors"}, bad, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        basic_vec[0] = '{3, 4, 1'b0, 25, 0};
        basic_vec[1] = '{-3, -4, 1'b0, 25, 0};
        basic_vec[2] = '{0, 0, 1'b0, 0, 0};
        basic_vec[3] = '{1, 1, 1'b0, 2, 0};
        basic_vec[4] = '{-1, 0, 1'b0, 1, 0};
        basic_vec[5] = '{100, 0, 1'b0, 10000, 0};
        basic_vec[6] = '{0, -200, 1'b0, 40000, 0};
        basic_vec[7] = '{5, 12, 1'b1, 169, 0};
        sat_vec[0] = '{32767, 32767, 1'b0, 65535, 32766};
        sat_vec[1] = '{-32768, -32768, 1'b0, 65535, 32768};
        for (int i = 2; i < N; i++) sat_vec[i] = '{0, 0, (i == N - 1), 0, 0};
        clear_model();

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        checkEq("reset bin_ready", bin_ready, 0);
        checkEq("reset mag_valid", mag_valid, 0);
        checkEq("reset mag_sq", mag_sq, 0);
        checkEq("reset frame_start", frame_start, 0);
        checkEq("reset frame_err", frame_err, 0);
        checkEq("reset sat_count", sat_count, 0);
        checkEq("reset frame_count", frame_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkEq("bin_ready after reset", bin_ready, 1);
        tick();

        // Basic frame from the vector table
        start_phase();
        for (int i = 0; i < N; i++)
            applyStimulus(basic_vec[i].re, basic_vec[i].im, basic_vec[i].last);
        drain("basic");
        checkOutput("basic");
        for (int i = 0; i < N && i < got.size(); i++) begin
            checkEq($sformatf("basic table[%0d]", i), got[i], basic_vec[i].exp_mag);
            checkEq($sformatf("basic table16[%0d]", i), got16[i], basic_vec[i].exp_mag16);
        end
        // Accept edge is one edge after the sampling negedge, output three edges later
        if (valid_cyc.size() > 0)
            checkEq("basic latency", valid_cyc[0] - last_accept_cyc, 4);
        checkEq("basic frame_count", frame_count, 1);

        // Saturation, with the SHIFT=16 instance alongside
        start_phase();
        for (int i = 0; i < N; i++)
            applyStimulus(sat_vec[i].re, sat_vec[i].im, sat_vec[i].last);
        drain("sat");
        checkOutput("sat");
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            checkEq($sformatf("sat table[%0d]", i), got[i], sat_vec[i].exp_mag);
            checkEq($sformatf("sat table16[%0d]", i), got16[i], sat_vec[i].exp_mag16);
        end
        checkEq("sat sat_count", sat_count, 2);
        checkEq("sat sat_count16", sat_count16, 0);

        // Backpressure: three frames with bin_valid held high
        start_phase();
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++)
                applyStimulus(rand_val(), rand_val(), (i == N - 1));
        drain("backpressure");
        checkOutput("backpressure");
        if (valid_cyc.size() >= 3 * N) begin
            // GAP hold cycles plus the one IDLE cycle that observes the next full bank
            checkEq("bp gap 1-2", valid_cyc[N] - valid_cyc[N-1], GAP + 2);
            checkEq("bp gap 2-3", valid_cyc[2*N] - valid_cyc[2*N-1], GAP + 2);
            if (ready_at.exists(valid_cyc[N-1]) && ready_at.exists(valid_cyc[N-1] + 1)) begin
                checkEq("bp ready at frame1 last output", ready_at[valid_cyc[N-1]], 0);
                checkEq("bp ready after bank freed", ready_at[valid_cyc[N-1] + 1], 1);
            end else begin
                checkEq("bp ready history present", 0, 1);
            end
        end

        // Framing error: last on bin 4, then a full frame
        start_phase();
        for (int i = 0; i < 5; i++) applyStimulus(rand_val(), rand_val(), (i == 4));
        for (int i = 0; i < N; i++) applyStimulus(rand_val(), rand_val(), (i == N - 1));
        drain("early_last");
        checkOutput("early_last");
        checkEq("early_last frame_err pulses", err_pulses, 1);
        checkEq("early_last frame_count", frame_count, 1);

        // Missing last: 9 bins without last, then 7 more closing a frame from bin 8
        start_phase();
        for (int i = 0; i < 9; i++) applyStimulus(100 + i, -i, 1'b0);
        for (int i = 0; i < N - 1; i++) applyStimulus(200 + i, i, (i == N - 2));
        drain("missing_last");
        checkOutput("missing_last");
        checkEq("missing_last frame_err pulses", err_pulses, 1);
        if (got.size() > 0) checkEq("missing_last first output", got[0], 108 * 108 + 64);

        // Randomized frames, some preceded by short errored frames
        start_phase();
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                int len;
                len = $urandom_range(1, N - 1);
                for (int i = 0; i < len; i++) applyStimulus(rand_val(), rand_val(), (i == len - 1));
            end
            for (int i = 0; i < N; i++) begin
                applyStimulus(rand_val(), rand_val(), (i == N - 1));
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        drain("random");
        checkOutput("random");

        // Reset during emission at rd_idx 3
        start_phase();
        for (int i = 0; i < N; i++)
            applyStimulus(basic_vec[i].re, basic_vec[i].im, basic_vec[i].last);
        w = 0;
        while (got.size() < 3 && w < 200) begin
            tick();
            w++;
        end
        checkEq("midreset reached rd_idx 3", (got.size() >= 3), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkEq("midreset mag_valid", mag_valid, 0);
        checkEq("midreset mag_sq", mag_sq, 0);
        checkEq("midreset frame_start", frame_start, 0);
        checkEq("midreset frame_count", frame_count, 0);
        checkEq("midreset sat_count", sat_count, 0);
        checkEq("midreset bin_ready", bin_ready, 1);
        clear_model();
        repeat (20) tick();
        checkEq("midreset no stale output", got.size(), 0);
        for (int i = 0; i < N; i++) applyStimulus(rand_val(), rand_val(), (i == N - 1));
        drain("after_reset");
        checkOutput("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mag_sq_framer.md
MAG_SQ_FRAMER -- requirements
Module: mag_sq_framer

Interface
REQ-001 Parameters SHALL be:
- N, 8, bins per frame, 2..16.
- W, 16, output magnitude width.
- IN_W, 16, signed re/im width.
- SHIFT, 0, right shift applied to re^2+im^2 before saturation.
- GAP, 2, idle cycles after each emitted frame, 0..15.

REQ-002 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- bin_valid  in  1  input bin present.
- bin_ready  out  1  framer can accept a bin.
- bin_re  in  IN_W  signed real part.
- bin_im  in  IN_W  signed imaginary part.
- bin_last  in  1  marks last bin of an FFT frame.
- mag_valid  out  1  mag_sq valid this cycle; no backpressure.
- mag_sq  out  W  saturated, shifted magnitude squared.
- frame_start  out  1  pulse with the first mag_valid of each frame.
- frame_err  out  1  one-cycle pulse on a framing error.
- sat_count  out  16  saturated-bin counter, wraps.
- frame_count  out  16  emitted-frame counter, wraps.

Function
REQ-003 An input bin SHALL be accepted on a rising edge where bin_valid && bin_ready.

REQ-004 The arithmetic pipeline SHALL run in two stages:
- Stage 1 registers re*re and im*im, each 2*IN_W bits, unsigned result, at the accept edge.
- Stage 2 sums them to 2*IN_W+1 bits, shifts right by SHIFT, and saturates to 2^W-1.
- Stage 2 writes the result into the active bank at write index wr_idx on the next edge.

REQ-005 Each saturated write SHALL increment sat_count by 1.

REQ-006 Storage SHALL be two banks of N x W (ping-pong), each with a full flag.
- The fill side writes one bank while the emit side reads the other.

REQ-007 Frame completion and framing errors SHALL be handled as follows:
- Complete frame: an accepted bin with wr_idx==N-1 and bin_last=1. Its write sets the bank full, toggles the fill bank and clears wr_idx.
- Error: an accepted bin with bin_last=1 and wr_idx!=N-1, or with wr_idx==N-1 and bin_last=0.
- On error: pulse frame_err when the bin is written, discard the partial bank (not marked full), and restart at wr_idx=0 in the same bank.

REQ-008 bin_ready SHALL be 0 whenever the fill bank is full (both banks full); otherwise it SHALL be 1.

REQ-009 The emit FSM SHALL have states IDLE, EMIT, GAP:
- IDLE to EMIT when the emit bank's full flag is 1; clear rd_idx.
- EMIT: mag_valid=1 and mag_sq=bank[rd_idx] each cycle, rd_idx ascending 0..N-1, contiguous.
- frame_start=1 only at rd_idx==0.
- At rd_idx==N-1: clear that bank's full flag, toggle the emit bank, increment frame_count, go to GAP (or IDLE if GAP==0).
- GAP: hold mag_valid=0 for exactly GAP cycles, then go to IDLE.

REQ-010 Latency: when the emitter is IDLE and the last bin of a frame is accepted at edge E, the first mag_valid SHALL be high in the cycle after edge E+3.

REQ-011 mag_sq SHALL read 0 whenever mag_valid=0.

REQ-012 Full-flag clear (emit side) and full-flag set (fill side) on the same edge SHALL both take effect, since they target different banks.
- A full bank freed on edge E re-asserts bin_ready in the cycle after E.

REQ-013 Accepted bins in the pipeline SHALL never be dropped.
- While the final stage-2 write of a bank is pending, bin_ready SHALL be 0 if the other bank is full.

REQ-014 Counters SHALL wrap from 65535 to 0.

Reset
REQ-015 On reset SHALL hold:
- bin_ready=0 during reset, 1 on the first cycle after.
- mag_valid, mag_sq, frame_start, frame_err, sat_count, frame_count = 0.
- Both full flags 0; wr_idx, rd_idx, pipeline valids 0; fill bank = emit bank = 0; FSM = IDLE.

REQ-016 Reset asserted mid-fill or mid-emit SHALL abort all frames.
- No mag_valid SHALL appear after reset until a new complete frame is accepted.

Verification
REQ-017 Scenario, basic frame:
- Stimulus: N=8, SHIFT=0, bins (re,im)=(3,4), (-3,-4), (0,0), (1,1), (-1,0), (100,0), (0,-200), (5,12), last on bin 7.
- Response: mag_sq 25, 25, 0, 2, 1, 10000, 40000, 169, contiguous; frame_start on the first; first mag_valid 3 edges after the last accept; frame_count=1.

REQ-018 Scenario, saturation: (32767,32767) and (-32768,-32768) with SHIFT=0.
- Response: mag_sq=65535 both; sat_count=2.
- Same bins with SHIFT=16: 32766 and 32768, no saturation.

REQ-019 Scenario, backpressure: three frames offered back-to-back with bin_valid held at 1.
- Response: frames 1-2 fill both banks; bin_ready=0 until frame 1's last mag_valid edge.
- All 24 outputs are in order; GAP=2 idle cycles between frames.

REQ-020 Scenario, framing error: bin_last at bin 4, then a full 8-bin frame.
- Response: one frame_err pulse; only the 8-bin frame is emitted; frame_count=1.

REQ-021 Scenario, reset mid-emission: reset at rd_idx=3 for 1 cycle.
- Response: mag_valid=0 from the next cycle; all outputs 0; the next valid frame emits normally from bin 0.

REQ-022 Scenario, missing last: 9 bins with no bin_last.
- Response: frame_err at bin 7 (index N-1 without last); bin 8 starts a new frame at wr_idx=0.
